// File: rtl/divider_8bit_seq.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Start/Busy/Done handshake; results hold until the next completion or reset.
module divider_8bit_seq #(
   parameter int WIDTH = 8
) (
   input  logic             CLOCK_50,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DZERO = 2'd2;

   logic [1:0]       state_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] d_r;
   logic [WIDTH-1:0] r_r;

   logic [WIDTH:0]   rs_s;
   logic [WIDTH-1:0] diff_s;
   logic             ge_s;
   logic [WIDTH-1:0] q_next_s;
   logic [WIDTH-1:0] r_next_s;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   // The partial remainder never exceeds the divisor, so its top bit lives
   // only in the shifted value rs_s and need not be stored.
   always_comb begin
      rs_s     = {r_r, q_r[WIDTH-1]};
      diff_s   = rs_s[WIDTH-1:0] - d_r;
      ge_s     = (rs_s >= {1'b0, d_r});
      q_next_s = {q_r[WIDTH-2:0], ge_s};
      if (ge_s) begin
         r_next_s = diff_s;
      end else begin
         r_next_s = rs_s[WIDTH-1:0];
      end
   end

   // Control FSM, iteration datapath and registered result outputs.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_r   <= ST_IDLE;
         count_r   <= {CW{1'b0}};
         q_r       <= {WIDTH{1'b0}};
         d_r       <= {WIDTH{1'b0}};
         r_r       <= {WIDTH{1'b0}};
         Quotient  <= {WIDTH{1'b0}};
         Remainder <= {WIDTH{1'b0}};
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  q_r     <= Dividend;
                  d_r     <= Divisor;
                  r_r     <= {WIDTH{1'b0}};
                  count_r <= {CW{1'b0}};
                  if (Divisor != {WIDTH{1'b0}}) begin
                     state_r <= ST_RUN;
                     Busy    <= 1'b1;
                  end else begin
                     state_r <= ST_DZERO;
                  end
               end
            end
            ST_RUN: begin
               q_r     <= q_next_s;
               r_r     <= r_next_s;
               count_r <= count_r + CW'(1);
               if (count_r == LAST_ITER) begin
                  Quotient  <= q_next_s;
                  Remainder <= r_next_s;
                  DivByZero <= 1'b0;
                  Done      <= 1'b1;
                  Busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            ST_DZERO: begin
               // q_r still holds the dividend captured at accept.
               Quotient  <= {WIDTH{1'b1}};
               Remainder <= q_r;
               DivByZero <= 1'b1;
               Done      <= 1'b1;
               state_r   <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
